dmem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the 16-bit data memory (64 words, wr_en/rd_en, registered read).

---
 rtl/dmem_arbiter_if.sv | 23 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side command/response bundle for dmem_arbiter; one instance per requester.
interface dmem_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 6
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          done;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, done, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the 64x16 data memory: one access at a time, registered read.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed r0 priority instead of round-robin.
module dmem_arbiter #(
    parameter int DW     = 16,
    parameter int AW     = 6,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave r0,
    dmem_arbiter_if.slave r1,
    output logic          mem_wr_en,
    output logic          mem_rd_en,
    output logic [DW-1:0] mem_data_in,
    output logic [AW-1:0] mem_address,
    input  logic [DW-1:0] mem_data_out,
    output logic          busy
);
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          win;
    logic          sel_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;
    logic          any_req;

    assign any_req = r0.req | r1.req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    always_comb win = ~r0.req;
`else
    logic rr_q;

    // Pointer only moves on a contested pick; solo grants leave it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rr_q <= 1'b1;
        else if (state == IDLE && r0.req && r1.req)
            rr_q <= win;
    end

    always_comb begin
        win = r1.req;
        if (r0.req && r1.req)
            win = ~rr_q;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Command register doubles as the memory address/data drive, so it holds between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            cnt_q       <= '0;
            r0.rdata    <= '0;
            r1.rdata    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                sel_q       <= win;
                we_q        <= win ? r1.we    : r0.we;
                mem_address <= win ? r1.addr  : r0.addr;
                mem_data_in <= win ? r1.wdata : r0.wdata;
            end
            if (state == ACCESS)
                cnt_q <= CW'(RD_LAT);
            else if (state == WAIT)
                cnt_q <= cnt_q - 1'b1;
            if (state == WAIT && cnt_q == CW'(1)) begin
                if (sel_q)
                    r1.rdata <= mem_data_out;
                else
                    r0.rdata <= mem_data_out;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        r0.gnt    = 1'b0;
        r1.gnt    = 1'b0;
        r0.done   = 1'b0;
        r1.done   = 1'b0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (any_req)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                r0.gnt    = ~sel_q;
                r1.gnt    = sel_q;
                mem_wr_en = we_q;
                mem_rd_en = ~we_q;
                state_nxt = we_q ? DONE : WAIT;
            end
            WAIT: begin
                if (cnt_q == CW'(1))
                    state_nxt = DONE;
            end
            DONE: begin
                r0.done   = ~sel_q;
                r1.done   = sel_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64x16 registered-read memory.
module tb_dmem_arbiter;
    localparam int DW     = 16;
    localparam int AW     = 6;
    localparam int RD_LAT = 1;

    typedef struct {
        bit          who;
        bit          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gnt_t;

    typedef struct {
        bit          who;
        bit          rd;
        logic [DW-1:0] data;
    } done_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_wr_en, mem_rd_en, busy;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_out;
    logic [DW-1:0] mem_arr [64];

    int compared = 0;
    int failed   = 0;
    int cyc      = 0;
    int gcyc     = 0;
    int glat     = 0;

    gnt_t  gq[$];
    done_t dq[$];

    dmem_arbiter_if #(.DW(DW), .AW(AW)) r0_if ();
    dmem_arbiter_if #(.DW(DW), .AW(AW)) r1_if ();

    dmem_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .r0           (r0_if),
        .r1           (r1_if),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_data_in  (mem_data_in),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_wr_en)
            mem_arr[mem_address] <= mem_data_in;
        if (mem_rd_en)
            mem_data_out <= mem_arr[mem_address];
    end

    // Monitor: every grant/strobe and every done pops and checks the next expectation.
    always @(negedge clk) begin
        gnt_t          g;
        done_t         d;
        logic [DW-1:0] got;
        if (rst) begin
            if (r0_if.gnt || r1_if.gnt || mem_wr_en || mem_rd_en) begin
                compared++;
                if (gq.size() == 0) begin
                    failed++;
                    $display("FAIL grant: got gnt0=%b gnt1=%b wr=%b rd=%b, required no activity",
                             r0_if.gnt, r1_if.gnt, mem_wr_en, mem_rd_en);
                end else begin
                    g = gq.pop_front();
                    if (r0_if.gnt != !g.who || r1_if.gnt != g.who || mem_wr_en != g.we ||
                        mem_rd_en != !g.we || mem_address != g.addr ||
                        (g.we && mem_data_in != g.wdata)) begin
                        failed++;
                        $display("FAIL grant: got gnt0=%b gnt1=%b wr=%b rd=%b addr=%h din=%h, required who=%0d we=%b addr=%h din=%h",
                                 r0_if.gnt, r1_if.gnt, mem_wr_en, mem_rd_en, mem_address, mem_data_in,
                                 g.who, g.we, g.addr, g.wdata);
                    end
                    gcyc = cyc;
                    glat = g.we ? 1 : 1 + RD_LAT;
                end
            end
            if (r0_if.done || r1_if.done) begin
                compared++;
                if (dq.size() == 0) begin
                    failed++;
                    $display("FAIL done: got done0=%b done1=%b, required none", r0_if.done, r1_if.done);
                end else begin
                    d   = dq.pop_front();
                    got = d.who ? r1_if.rdata : r0_if.rdata;
                    if (r0_if.done != !d.who || r1_if.done != d.who || cyc != gcyc + glat ||
                        (d.rd && got != d.data)) begin
                        failed++;
                        $display("FAIL done: got done0=%b done1=%b lat=%0d rdata=%h, required who=%0d lat=%0d rdata=%h",
                                 r0_if.done, r1_if.done, cyc - gcyc, got, d.who, glat, d.data);
                    end
                end
            end
        end
    end

    task automatic expect_gnt(input bit who, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata);
        gnt_t g;
        g.who = who; g.we = we; g.addr = addr; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic expect_txn(input bit who, input bit we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        done_t d;
        expect_gnt(who, we, addr, wdata);
        d.who = who; d.rd = !we; d.data = rdata;
        dq.push_back(d);
    endtask

    task automatic drive(input bit who, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (who) begin
            r1_if.req = 1'b1; r1_if.we = we; r1_if.addr = addr; r1_if.wdata = wdata;
        end else begin
            r0_if.req = 1'b1; r0_if.we = we; r0_if.addr = addr; r0_if.wdata = wdata;
        end
    endtask

    // Requests drop on their own grant; returns once everything is served and idle.
    task automatic run_pending();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            if (r0_if.gnt) r0_if.req = 1'b0;
            if (r1_if.gnt) r1_if.req = 1'b0;
        end while ((r0_if.req || r1_if.req || busy) && n < 200);
        if (n >= 200) begin
            compared++;
            failed++;
            $display("FAIL timeout: got busy=%b after %0d cycles, required idle", busy, n);
        end
    endtask

    initial begin
        int   n;
        logic act;
        rst = 1'b0;
        r0_if.req = 1'b0; r0_if.we = 1'b0; r0_if.addr = '0; r0_if.wdata = '0;
        r1_if.req = 1'b0; r1_if.we = 1'b0; r1_if.addr = '0; r1_if.wdata = '0;

        repeat (10) begin
            @(posedge clk); #1;
            r0_if.req = 1'($urandom); r0_if.we = 1'($urandom);
            r0_if.addr = AW'($urandom); r0_if.wdata = DW'($urandom);
            r1_if.req = 1'($urandom); r1_if.we = 1'($urandom);
            r1_if.addr = AW'($urandom); r1_if.wdata = DW'($urandom);
        end
        compared++;
        if ({r0_if.gnt, r0_if.done, r0_if.rdata, r1_if.gnt, r1_if.done, r1_if.rdata,
             mem_wr_en, mem_rd_en, mem_data_in, mem_address, busy} != '0) begin
            failed++;
            $display("FAIL reset_outputs: got rdata0=%h rdata1=%h addr=%h din=%h busy=%b, required all 0",
                     r0_if.rdata, r1_if.rdata, mem_address, mem_data_in, busy);
        end

        @(negedge clk);
        r0_if.req = 1'b0; r1_if.req = 1'b0;
        rst = 1'b1;
        act = 1'b0;
        repeat (5) begin
            @(negedge clk);
            act = act | busy | mem_wr_en | mem_rd_en | r0_if.gnt | r1_if.gnt | r0_if.done | r1_if.done;
        end
        compared++;
        if (act) begin
            failed++;
            $display("FAIL post_reset_idle: got activity=1, required 0");
        end

        expect_txn(1'b0, 1'b1, 6'h00, 16'h0C60, 16'h0000);
        drive(1'b0, 1'b1, 6'h00, 16'h0C60);
        run_pending();

        expect_txn(1'b0, 1'b0, 6'h00, 16'h0000, 16'h0C60);
        drive(1'b0, 1'b0, 6'h00, 16'h0000);
        run_pending();

        expect_txn(1'b0, 1'b1, 6'h01, 16'hFFF0, 16'h0000);
        expect_txn(1'b1, 1'b1, 6'h02, 16'h11E4, 16'h0000);
        drive(1'b0, 1'b1, 6'h01, 16'hFFF0);
        drive(1'b1, 1'b1, 6'h02, 16'h11E4);
        run_pending();

`ifdef DMEM_ARB_FIXED_PRIO_EN
        expect_txn(1'b0, 1'b1, 6'h01, 16'hFFF0, 16'h0000);
        expect_txn(1'b1, 1'b1, 6'h02, 16'h11E4, 16'h0000);
`else
        expect_txn(1'b1, 1'b1, 6'h02, 16'h11E4, 16'h0000);
        expect_txn(1'b0, 1'b1, 6'h01, 16'hFFF0, 16'h0000);
`endif
        drive(1'b0, 1'b1, 6'h01, 16'hFFF0);
        drive(1'b1, 1'b1, 6'h02, 16'h11E4);
        run_pending();

        expect_txn(1'b0, 1'b1, 6'h3F, 16'hA5A5, 16'h0000);
        drive(1'b0, 1'b1, 6'h3F, 16'hA5A5);
        run_pending();
        expect_txn(1'b1, 1'b0, 6'h3F, 16'h0000, 16'hA5A5);
        drive(1'b1, 1'b0, 6'h3F, 16'h0000);
        run_pending();

        expect_gnt(1'b1, 1'b0, 6'h02, 16'h0000);
        drive(1'b1, 1'b0, 6'h02, 16'h0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r1_if.gnt && n < 20);
        if (n >= 20) begin
            compared++;
            failed++;
            $display("FAIL abort_gnt: got no r1 grant in %0d cycles, required grant", n);
        end
        r1_if.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if ({mem_wr_en, mem_rd_en, r1_if.done, r1_if.rdata, r0_if.rdata, busy} != '0) begin
            failed++;
            $display("FAIL abort_reset: got wr=%b rd=%b done1=%b rdata1=%h rdata0=%h busy=%b, required all 0",
                     mem_wr_en, mem_rd_en, r1_if.done, r1_if.rdata, r0_if.rdata, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        expect_txn(1'b1, 1'b0, 6'h02, 16'h0000, 16'h11E4);
        drive(1'b1, 1'b0, 6'h02, 16'h0000);
        run_pending();

        expect_txn(1'b0, 1'b0, 6'h01, 16'h0000, 16'hFFF0);
        drive(1'b0, 1'b0, 6'h01, 16'h0000);
        run_pending();

        expect_txn(1'b1, 1'b0, 6'h02, 16'h0000, 16'h11E4);
        drive(1'b1, 1'b0, 6'h02, 16'h0000);
        run_pending();
        compared++;
        if (r0_if.rdata != 16'hFFF0) begin
            failed++;
            $display("FAIL r0_rdata_held: got %h, required fff0", r0_if.rdata);
        end

        repeat (3) @(negedge clk);
        compared++;
        if (gq.size() != 0 || dq.size() != 0) begin
            failed++;
            $display("FAIL pending: got %0d grants %0d dones outstanding, required 0 0", gq.size(), dq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
